// File: rtl/clock_period_meter.sv
// Measures the rising-to-rising period and the high time of a slow asynchronous
// input in clk_in cycles, and flags an input that has stopped toggling.
module clock_period_meter #(
    parameter int WIDTH   = 25,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             sig_in,
    output logic             rise_tick,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             period_valid,
    output logic             stalled
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stalled_q, stalled_d;
    logic             rise_tick_q, rise_tick_d;
    logic             rise;

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_d      = high_q;
        stalled_d   = stalled_q;
        valid_d     = 1'b0;
        rise_tick_d = rise;

        case (state_q)
            IDLE: begin
                // The first edge after reset or a stall only starts a measurement.
                if (rise) begin
                    cnt_d   = ONE_C;
                    hcnt_d  = ONE_C;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d  = cnt_q;
                    high_d    = hcnt_q;
                    valid_d   = 1'b1;
                    stalled_d = 1'b0;
                    cnt_d     = ONE_C;
                    hcnt_d    = ONE_C;
                end else if (cnt_q < TIMEOUT_C) begin
                    cnt_d  = cnt_q + ONE_C;
                    hcnt_d = hcnt_q + WIDTH'(s2_q);
                end else begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
            rise_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= sig_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
            rise_tick_q <= rise_tick_d;
        end
    end

    assign rise_tick    = rise_tick_q;
    assign period_out   = period_q;
    assign high_out     = high_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: square waves of known shape, stall,
// mid-period reset and input held high across reset.
module tb_clock_period_meter;

    localparam int WIDTH   = 25;
    localparam int TIMEOUT = 1000;

    logic             clk_in;
    logic             reset_in;
    logic             sig_in;
    logic             rise_tick;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             period_valid;
    logic             stalled;

    int errors;
    int checks;
    int cycleNo;
    int validCount;
    int riseCount;
    int lastRiseCycle;
    int expPeriod;
    int expHigh;
    bit spacingOn;
    bit prevValid;

    clock_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .sig_in       (sig_in),
        .rise_tick    (rise_tick),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycleNo);
        end
    endtask

    // One clock, sampled 1 time unit after the edge; checks every result pulse.
    task automatic cycle();
        @(posedge clk_in);
        #1;
        cycleNo++;
        if (period_valid) begin
            validCount++;
            checkOutput("period_out", 32'(period_out), 32'(expPeriod));
            checkOutput("high_out", 32'(high_out), 32'(expHigh));
            checkOutput("valid_gap", 32'(prevValid), 32'd0);
            checkOutput("stall_clear", 32'(stalled), 32'd0);
        end
        if (rise_tick) begin
            riseCount++;
            if (spacingOn && riseCount > 1)
                checkOutput("rise_spacing", 32'(cycleNo - lastRiseCycle), 32'(expPeriod));
            lastRiseCycle = cycleNo;
        end
        prevValid = period_valid;
    endtask

    task automatic applyStimulus(input int highCycles, input int lowCycles, input int periods);
        for (int p = 0; p < periods; p++) begin
            sig_in = 1'b1;
            repeat (highCycles) cycle();
            sig_in = 1'b0;
            repeat (lowCycles) cycle();
        end
    endtask

    task automatic doReset(input bit sigLevel, input int len);
        sig_in   = sigLevel;
        reset_in = 1'b0;
        repeat (len) cycle();
        reset_in   = 1'b1;
        validCount = 0;
        riseCount  = 0;
        prevValid  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rise_tick"}, 32'(rise_tick), 32'd0);
        checkOutput({tag, "_period"}, 32'(period_out), 32'd0);
        checkOutput({tag, "_high"}, 32'(high_out), 32'd0);
        checkOutput({tag, "_valid"}, 32'(period_valid), 32'd0);
        checkOutput({tag, "_stalled"}, 32'(stalled), 32'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cycleNo       = 0;
        validCount    = 0;
        riseCount     = 0;
        lastRiseCycle = 0;
        spacingOn     = 1'b0;
        prevValid     = 1'b0;
        expPeriod     = 0;
        expHigh       = 0;
        sig_in        = 1'b0;
        reset_in      = 1'b0;

        // Reset state and 2 high / 2 low wave.
        doReset(1'b0, 3);
        checkAllZero("reset");
        expPeriod = 4;
        expHigh   = 2;
        applyStimulus(2, 2, 5);
        checkOutput("t1_valid_count", 32'(validCount), 32'd4);
        checkOutput("t1_rise_count", 32'(riseCount), 32'd5);
        checkOutput("t1_stalled", 32'(stalled), 32'd0);
        checkOutput("t1_period", 32'(period_out), 32'd4);
        checkOutput("t1_high", 32'(high_out), 32'd2);

        // 100 high / 100 low, with rise_tick spacing checked.
        doReset(1'b0, 2);
        expPeriod = 200;
        expHigh   = 100;
        spacingOn = 1'b1;
        applyStimulus(100, 100, 3);
        spacingOn = 1'b0;
        checkOutput("t2_valid_count", 32'(validCount), 32'd2);
        checkOutput("t2_rise_count", 32'(riseCount), 32'd3);
        checkOutput("t2_period", 32'(period_out), 32'd200);

        // 3 high / 7 low; the first rise only arms.
        doReset(1'b0, 2);
        expPeriod = 10;
        expHigh   = 3;
        applyStimulus(3, 7, 1);
        checkOutput("t3_first_rise_no_valid", 32'(validCount), 32'd0);
        checkOutput("t3_first_rise_seen", 32'(riseCount), 32'd1);
        applyStimulus(3, 7, 3);
        checkOutput("t3_valid_count", 32'(validCount), 32'd3);
        checkOutput("t3_high", 32'(high_out), 32'd3);

        // Stall after 3 periods, then restart.
        doReset(1'b0, 2);
        applyStimulus(3, 7, 3);
        checkOutput("t4_valid_before_stall", 32'(validCount), 32'd2);
        for (int i = 0; i < 2 * TIMEOUT && !stalled; i++) cycle();
        checkOutput("t4_stall_seen", 32'(stalled), 32'd1);
        checkOutput("t4_stall_delay", 32'(cycleNo - lastRiseCycle), 32'(TIMEOUT));
        checkOutput("t4_period_kept", 32'(period_out), 32'd10);
        checkOutput("t4_high_kept", 32'(high_out), 32'd3);
        applyStimulus(3, 7, 1);
        checkOutput("t4_arm_still_stalled", 32'(stalled), 32'd1);
        checkOutput("t4_arm_no_valid", 32'(validCount), 32'd2);
        applyStimulus(3, 7, 1);
        checkOutput("t4_restart_valid", 32'(validCount), 32'd3);
        checkOutput("t4_restart_stalled", 32'(stalled), 32'd0);

        // One-cycle reset in the middle of a period.
        doReset(1'b0, 2);
        applyStimulus(3, 7, 2);
        checkOutput("t5_valid_before", 32'(validCount), 32'd1);
        sig_in = 1'b1;
        repeat (2) cycle();
        sig_in   = 1'b0;
        reset_in = 1'b0;
        cycle();
        reset_in = 1'b1;
        checkAllZero("t5_midreset");
        validCount = 0;
        prevValid  = 1'b0;
        repeat (7) cycle();
        applyStimulus(3, 7, 3);
        checkOutput("t5_valid_after", 32'(validCount), 32'd2);
        checkOutput("t5_period_after", 32'(period_out), 32'd10);

        // Input held high through and after reset.
        doReset(1'b1, 3);
        lastRiseCycle = cycleNo;
        begin
            int releaseCycle;
            releaseCycle = cycleNo;
            repeat (10) cycle();
            checkOutput("t6_rise_count", 32'(riseCount), 32'd1);
            checkOutput("t6_rise_delay", 32'(lastRiseCycle - releaseCycle), 32'd3);
            checkOutput("t6_no_valid", 32'(validCount), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
